// File: rtl/d8_pkg.sv
// d8_pkg: shared widths and arbiter FSM state encoding
package d8_pkg;
  localparam int ADR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD1 = 2'd1;
  localparam logic [1:0] ST_RD2 = 2'd2;
endpackage

// File: rtl/d8_wait_timer.sv
// d8_wait_timer: saturating host wait counter raising hold after MAX_WAIT blocked cycles
module d8_wait_timer #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic blocked,
  input  logic grant,
  output logic hold
);
  generate
    if (MAX_WAIT == 0) begin : g_off
      assign hold = 1'b0;
    end else begin : g_on
      logic [CNT_W-1:0] cnt;
      logic hold_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt <= '0;
          hold_q <= 1'b0;
        end else if (grant) begin
          cnt <= '0;
          hold_q <= 1'b0;
        end else if (blocked) begin
          cnt <= (cnt == CNT_W'(MAX_WAIT)) ? cnt : cnt + 1'b1;
          hold_q <= hold_q | (cnt == CNT_W'(MAX_WAIT - 1));
        end
      end
      assign hold = hold_q;
    end
  endgenerate
endmodule

// File: rtl/d8_dmem_arbiter.sv
// d8_dmem_arbiter: shares data memory between CPU MEM stage and host port with anti-starvation hold
module d8_dmem_arbiter
  import d8_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cpu_req,
  input  logic              cpu_w,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              host_req,
  input  logic              host_w,
  input  logic [ADR_W-1:0]  host_adr,
  input  logic [DATA_W-1:0] host_din,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              cpu_hold,
  output logic [ADR_W-1:0]  md_adr,
  output logic [DATA_W-1:0] md_din,
  output logic              md_w,
  input  logic [DATA_W-1:0] md_dout
);
  logic [1:0] state;
  logic [1:0] state_nx;
  logic grant_host;
  logic blocked;
  always_comb begin
    grant_host = sys_rst & (state == ST_IDLE) & host_req & (cpu_hold | ~cpu_req);
    blocked = (state == ST_IDLE) & host_req & ~grant_host;
    host_ack = grant_host;
    md_adr = grant_host ? host_adr : cpu_adr;
    md_din = grant_host ? host_din : cpu_din;
    md_w = sys_rst & (grant_host ? host_w : (cpu_req & cpu_w & ~cpu_hold));
    host_rvalid = sys_rst & (state == ST_RD2);
    state_nx = (state == ST_IDLE) ? ((grant_host & ~host_w) ? ST_RD1 : ST_IDLE) :
               (state == ST_RD1) ? ST_RD2 : ST_IDLE;
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state <= ST_IDLE;
      host_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_RD1) host_rdata <= md_dout;
    end
  end
  d8_wait_timer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_timer (
    .clk(sys_clk),
    .rst_n(sys_rst),
    .blocked(blocked),
    .grant(grant_host),
    .hold(cpu_hold)
  );
endmodule

// File: tb/tb_d8_dmem_arbiter.sv
// tb_d8_dmem_arbiter: scoreboard bench for the data memory arbiter
module tb_d8_dmem_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic cpu_req = 1'b0;
  logic cpu_w = 1'b0;
  logic [7:0] cpu_adr = 8'h00;
  logic [7:0] cpu_din = 8'h00;
  logic host_req = 1'b0;
  logic host_w = 1'b0;
  logic [7:0] host_adr = 8'h00;
  logic [7:0] host_din = 8'h00;
  logic host_ack;
  logic host_rvalid;
  logic [7:0] host_rdata;
  logic cpu_hold;
  logic [7:0] md_adr;
  logic [7:0] md_din;
  logic md_w;
  logic [7:0] md_dout;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int pass = 0;
  int total = 0;
  d8_dmem_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .cpu_req(cpu_req),
    .cpu_w(cpu_w),
    .cpu_adr(cpu_adr),
    .cpu_din(cpu_din),
    .host_req(host_req),
    .host_w(host_w),
    .host_adr(host_adr),
    .host_din(host_din),
    .host_ack(host_ack),
    .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .cpu_hold(cpu_hold),
    .md_adr(md_adr),
    .md_din(md_din),
    .md_w(md_w),
    .md_dout(md_dout)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) begin
    if (md_w === 1'b1) mem[md_adr] <= md_din;
    md_dout <= mem[md_adr];
  end
  always @(negedge sys_clk) begin
    if (host_rvalid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected_rvalid: rdata=%h with no read outstanding", host_rdata);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (host_rdata !== e) $display("FAIL sb_rdata: got %h expected %h", host_rdata, e);
        else pass++;
      end
    end
  end
  task automatic test_reset;
    sys_rst = 1'b0;
    host_req = 1'b1;
    host_w = 1'b1;
    cpu_req = 1'b1;
    cpu_w = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    total++; if (md_w !== 1'b0) $display("FAIL rst_md_w: got %b expected 0", md_w); else pass++;
    total++; if (host_ack !== 1'b0) $display("FAIL rst_ack: got %b expected 0", host_ack); else pass++;
    total++; if (cpu_hold !== 1'b0) $display("FAIL rst_hold: got %b expected 0", cpu_hold); else pass++;
    total++; if (host_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b expected 0", host_rvalid); else pass++;
    total++; if (host_rdata !== 8'h00) $display("FAIL rst_rdata: got %h expected 00", host_rdata); else pass++;
    host_req = 1'b0;
    host_w = 1'b0;
    cpu_req = 1'b0;
    cpu_w = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask
  task automatic test_host_write;
    @(negedge sys_clk);
    host_req = 1'b1; host_w = 1'b1; host_adr = 8'h10; host_din = 8'hA5;
    #1;
    total++; if (host_ack !== 1'b1) $display("FAIL wr_ack: got %b expected 1", host_ack); else pass++;
    total++; if (md_adr !== 8'h10) $display("FAIL wr_md_adr: got %h expected 10", md_adr); else pass++;
    total++; if (md_w !== 1'b1) $display("FAIL wr_md_w: got %b expected 1", md_w); else pass++;
    total++; if (md_din !== 8'hA5) $display("FAIL wr_md_din: got %h expected a5", md_din); else pass++;
    @(negedge sys_clk);
    host_req = 1'b0; host_w = 1'b0;
    @(negedge sys_clk);
    host_req = 1'b1; host_adr = 8'h10;
    #1;
    total++; if (host_ack !== 1'b1) $display("FAIL rd_ack: got %b expected 1", host_ack); else pass++;
    exp_q.push_back(8'hA5);
    @(negedge sys_clk);
    host_req = 1'b0;
    #1;
    total++; if (host_rvalid !== 1'b0) $display("FAIL rd_rvalid_t1: got %b expected 0", host_rvalid); else pass++;
    @(negedge sys_clk);
    #1;
    total++; if (host_rvalid !== 1'b1) $display("FAIL rd_rvalid_t2: got %b expected 1", host_rvalid); else pass++;
    total++; if (host_rdata !== 8'hA5) $display("FAIL rd_rdata: got %h expected a5", host_rdata); else pass++;
    @(negedge sys_clk);
    #1;
    total++; if (host_rvalid !== 1'b0) $display("FAIL rd_rvalid_t3: got %b expected 0", host_rvalid); else pass++;
  endtask
  task automatic test_priority;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_w = 1'b1; cpu_adr = 8'h20; cpu_din = 8'h11;
    host_req = 1'b1; host_w = 1'b0; host_adr = 8'h20;
    #1;
    total++; if (host_ack !== 1'b0) $display("FAIL pri_ack: got %b expected 0", host_ack); else pass++;
    total++; if (md_w !== 1'b1 || md_adr !== 8'h20 || md_din !== 8'h11) $display("FAIL pri_cpu_wr: got w=%b adr=%h din=%h expected w=1 adr=20 din=11", md_w, md_adr, md_din); else pass++;
    @(negedge sys_clk);
    cpu_req = 1'b0; cpu_w = 1'b0;
    #1;
    total++; if (host_ack !== 1'b1 || md_adr !== 8'h20 || md_w !== 1'b0) $display("FAIL pri_host_grant: got ack=%b adr=%h w=%b expected ack=1 adr=20 w=0", host_ack, md_adr, md_w); else pass++;
    exp_q.push_back(8'h11);
    @(negedge sys_clk);
    host_req = 1'b0;
    @(negedge sys_clk);
    #1;
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 8'h11) $display("FAIL pri_rdata: got v=%b d=%h expected v=1 d=11", host_rvalid, host_rdata); else pass++;
  endtask
  task automatic test_starvation;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_w = 1'b1; cpu_adr = 8'h30; cpu_din = 8'h77;
    host_req = 1'b1; host_w = 1'b0; host_adr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge sys_clk);
      #1;
      total++; if (host_ack !== 1'b0 || cpu_hold !== 1'b0 || md_w !== 1'b1) $display("FAIL starve_blocked_c%0d: got ack=%b hold=%b w=%b expected 0 0 1", i + 1, host_ack, cpu_hold, md_w); else pass++;
    end
    @(negedge sys_clk);
    #1;
    total++; if (cpu_hold !== 1'b1) $display("FAIL starve_hold_c5: got %b expected 1", cpu_hold); else pass++;
    total++; if (host_ack !== 1'b1) $display("FAIL starve_ack_c5: got %b expected 1", host_ack); else pass++;
    total++; if (md_w !== 1'b0 || md_adr !== 8'h20) $display("FAIL starve_suppress_c5: got w=%b adr=%h expected w=0 adr=20", md_w, md_adr); else pass++;
    if (host_ack === 1'b1) exp_q.push_back(8'h11);
    @(negedge sys_clk);
    host_req = 1'b0;
    #1;
    total++; if (cpu_hold !== 1'b0 || host_ack !== 1'b0) $display("FAIL starve_c6: got hold=%b ack=%b expected 0 0", cpu_hold, host_ack); else pass++;
    total++; if (md_w !== 1'b1 || md_adr !== 8'h30) $display("FAIL starve_cpu_resume: got w=%b adr=%h expected w=1 adr=30", md_w, md_adr); else pass++;
    @(negedge sys_clk);
    cpu_req = 1'b0; cpu_w = 1'b0;
    #1;
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 8'h11) $display("FAIL starve_rdata: got v=%b d=%h expected v=1 d=11", host_rvalid, host_rdata); else pass++;
  endtask
  task automatic test_back_to_back;
    @(negedge sys_clk);
    host_req = 1'b1; host_w = 1'b0; host_adr = 8'h01;
    #1;
    total++; if (host_ack !== 1'b1) $display("FAIL b2b_ack_t0: got %b expected 1", host_ack); else pass++;
    exp_q.push_back(8'h3C);
    @(negedge sys_clk);
    #1;
    total++; if (host_ack !== 1'b0) $display("FAIL b2b_noack_rd1: got %b expected 0", host_ack); else pass++;
    @(negedge sys_clk);
    host_adr = 8'h02;
    #1;
    total++; if (host_ack !== 1'b0 || host_rvalid !== 1'b1 || host_rdata !== 8'h3C) $display("FAIL b2b_t2: got ack=%b v=%b d=%h expected 0 1 3c", host_ack, host_rvalid, host_rdata); else pass++;
    @(negedge sys_clk);
    #1;
    total++; if (host_ack !== 1'b1 || cpu_hold !== 1'b0) $display("FAIL b2b_ack_t3: got ack=%b hold=%b expected 1 0", host_ack, cpu_hold); else pass++;
    exp_q.push_back(8'hC3);
    @(negedge sys_clk);
    host_req = 1'b0;
    #1;
    total++; if (host_rvalid !== 1'b0) $display("FAIL b2b_t4: got %b expected 0", host_rvalid); else pass++;
    @(negedge sys_clk);
    #1;
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 8'hC3) $display("FAIL b2b_t5: got v=%b d=%h expected 1 c3", host_rvalid, host_rdata); else pass++;
  endtask
  task automatic test_reset_mid_read;
    @(negedge sys_clk);
    host_req = 1'b1; host_w = 1'b0; host_adr = 8'h10;
    #1;
    total++; if (host_ack !== 1'b1) $display("FAIL mid_ack: got %b expected 1", host_ack); else pass++;
    @(negedge sys_clk);
    host_req = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    total++; if (host_rvalid !== 1'b0 || host_rdata !== 8'h00) $display("FAIL mid_after_rst: got v=%b d=%h expected 0 00", host_rvalid, host_rdata); else pass++;
    @(negedge sys_clk);
    #1;
    total++; if (host_rvalid !== 1'b0) $display("FAIL mid_no_rvalid: got %b expected 0", host_rvalid); else pass++;
    host_req = 1'b1;
    #1;
    total++; if (host_ack !== 1'b1) $display("FAIL mid_regrant: got %b expected 1", host_ack); else pass++;
    exp_q.push_back(8'hA5);
    @(negedge sys_clk);
    host_req = 1'b0;
    @(negedge sys_clk);
    #1;
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 8'hA5) $display("FAIL mid_rdata: got v=%b d=%h expected 1 a5", host_rvalid, host_rdata); else pass++;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h3C;
    mem[8'h02] = 8'hC3;
    test_reset();
    test_host_write();
    test_priority();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    repeat (3) @(negedge sys_clk);
    total++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d outstanding expected 0", exp_q.size()); else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/d8_dmem_arbiter.md
Name: d8_dmem_arbiter

Overview:
- Shares the single-port data memory (d8_mem_data) between two requesters:
  - the CPU MEM stage, which has fixed priority;
  - a host/debug port, which uses a req/ack handshake and returns registered read data.
- Prevents host starvation: after the host has waited MAX_WAIT cycles, the block raises cpu_hold to freeze the pipeline.
- Sits between the EX/MEM pipeline register, the host debug logic and d8_mem_data.

Parameters:
- MAX_WAIT, 4: cycles the host may be blocked before cpu_hold asserts. 0 disables hold, so the CPU always wins.
- CNT_W, 3: width of the wait counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- sys_clk  in  1  system clock; every register updates on the rising edge.
- sys_rst  in  1  synchronous reset, active-low.
- cpu_req  in  1  MEM stage accesses data memory this cycle (load or store).
- cpu_w  in  1  MEM stage access is a write.
- cpu_adr  in  8  MEM stage address.
- cpu_din  in  8  MEM stage write data.
- host_req  in  1  host access pending; must stay stable until host_ack.
- host_w  in  1  host access is a write.
- host_adr  in  8  host address.
- host_din  in  8  host write data.
- host_ack  out  1  host access performed this cycle (combinational grant).
- host_rvalid  out  1  one-cycle pulse: host_rdata is valid.
- host_rdata  out  8  registered host read data; held until the next host read completes.
- cpu_hold  out  1  registered request to freeze the pipeline (gates ah_en and the MEM stage).
- md_adr  out  8  data memory address.
- md_din  out  8  data memory write data.
- md_w  out  1  data memory write enable.
- md_dout  in  8  data memory read data, valid one cycle after the address (synchronous read).

Behaviour:
- Reset (sys_rst==0 at a clock edge):
  - state=IDLE, wait_cnt=0, cpu_hold=0, host_rvalid=0, host_rdata=0.
  - While sys_rst==0: md_w=0 and host_ack=0 combinationally.
  - Reset mid-operation abandons any pending host read; no rvalid is issued.
- FSM states:
  - IDLE: no host transaction in flight.
  - RD1: host read address was presented last cycle.
  - RD2: capture cycle.
- Grant rule (combinational, IDLE only):
  - grant_host = host_req & (cpu_hold | ~cpu_req).
  - host_ack = grant_host.
  - Memory mux: grant_host ? host : cpu.
  - md_w = grant_host ? host_w : (cpu_req & cpu_w & ~cpu_hold).
  - While cpu_hold=1, CPU writes are suppressed.
- Transitions:
  - IDLE, grant_host & ~host_w -> RD1.
  - IDLE, grant_host & host_w -> IDLE (write completes at the clock edge).
  - RD1 -> RD2.
  - RD2 -> IDLE.
- Read pipeline:
  - RD1 latches md_dout into host_rdata at its closing edge.
  - RD2 drives host_rvalid=1.
  - Read latency: ack at cycle T, rvalid at T+2.
  - In RD1 and RD2 the memory port belongs to the CPU; host_ack=0 even if host_req stays high.
  - The host must drop host_req after ack, or it issues a new request.
- Wait counter:
  - Increments when state==IDLE & host_req & ~grant_host, saturating at MAX_WAIT.
  - Clears on grant_host.
  - cpu_hold is set at the edge where wait_cnt==MAX_WAIT-1 and the host is still blocked, i.e. hold is visible after exactly MAX_WAIT blocked cycles.
  - cpu_hold clears at the edge where grant_host=1, so it is high for the grant cycle only.
- Boundary cases:
  - MAX_WAIT=0: cpu_hold is tied to 0 and the counter is unused.
  - Simultaneous cpu_req & host_req with hold=0: the CPU wins.
  - Host request arriving in RD1/RD2: not counted as waiting; the counter stays frozen.
  - Address and data are 8-bit with no arithmetic; no wrap issues.

Decomposition:
- d8_pkg holds:
  - the state encoding constants ST_IDLE, ST_RD1, ST_RD2 (2-bit);
  - the shared width constants ADR_W=8 and DATA_W=8.
- One natural sub-module: d8_wait_timer.
  - Saturating wait counter plus hold flag.
  - Inputs: blocked, grant. Output: hold. Parameter: MAX_WAIT.
- The top level holds the FSM, the memory mux and the read capture.

Test Plan:
- Reset: sys_rst=0 for 2 cycles with host_req=1, cpu_req=1, cpu_w=1 -> md_w=0, host_ack=0, cpu_hold=0, host_rvalid=0, host_rdata=0.
- Idle host write: cpu_req=0, host_req=1, host_w=1, host_adr=0x10, host_din=0xA5 -> host_ack=1 that cycle, md_adr=0x10, md_w=1. A later host read of 0x10 returns host_rdata=0xA5 with rvalid two cycles after ack.
- Priority: cpu_req=1 (write 0x20<-0x11) and host read of 0x20 in the same cycle, MAX_WAIT=4 -> CPU write occurs and host_ack=0. The next cycle, with cpu_req=0, the host is granted and later reads 0x11.
- Starvation: cpu_req held at 1 continuously with host_req=1 -> host_ack=0 for 4 cycles. cpu_hold=1 in cycle 5 together with host_ack=1, CPU write suppressed (md_w=host_w). cpu_hold=0 in cycle 6.
- Back-to-back reads: host reads 0x01 then 0x02 (req held) -> acks at T and T+3, rvalid at T+2 and T+5, data matches memory. No ack during RD1/RD2 even though req stays high.
- Reset mid-read: sys_rst=0 in the RD1 cycle -> no rvalid is ever issued, state returns to IDLE, host_rdata=0. The next request is granted normally.
